// File: rtl/mulc_pipe.sv
// -----------------------------------------------------------------------------
// mulc_pipe -- pipelined signed multiply-by-coefficient with rounding
//
// Computes D_OUT = clamp((D_IN * coef + 2^(FRAC-1)) >>> FRAC) with the full
// N+CW bit product and round-half-up.  The result leaves the block STAGES
// advance cycles after the sample is accepted.  The coefficient is a
// register loaded through C_WE/C_IN.  Each sample captures the coefficient
// that is current when the sample is accepted, so a later write cannot
// affect a sample that is already in the pipe.
//
// Optional feature (macro MULC_SAT_EN):
//   defined   -> results are saturated to the N-bit signed range, and
//                SAT_OUT flags each clamped sample
//   undefined -> the low N bits are kept (wrap-around), and SAT_OUT is 0
//
// Ports
//   CLK      rising-edge clock
//   RST      synchronous active-high reset (clears valids, outputs, coef)
//   EN       global enable; low freezes every register and ignores inputs
//   R_IN     input sample valid
//   D_IN     input sample (signed, N bits)
//   A_OUT    ready to upstream; a sample is accepted on R_IN && A_OUT
//   C_WE     coefficient write strobe (honoured only when EN=1)
//   C_IN     new coefficient (signed, CW bits, FRAC fractional bits)
//   RDY      downstream ready
//   R_OUT    output valid
//   D_OUT    output sample (signed, N bits)
//   SAT_OUT  current D_OUT was clamped
// -----------------------------------------------------------------------------
module mulc_pipe #(
  parameter int              N         = 16,
  parameter int              CW        = 16,
  parameter int              FRAC      = 15,
  parameter int              STAGES    = 2,
  parameter logic [CW-1:0]   COEF_INIT = CW'(16'h4000)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 R_IN,
  input  logic signed [N-1:0]  D_IN,
  output logic                 A_OUT,
  input  logic                 C_WE,
  input  logic signed [CW-1:0] C_IN,
  input  logic                 RDY,
  output logic                 R_OUT,
  output logic signed [N-1:0]  D_OUT,
  output logic                 SAT_OUT
);

  localparam int PW = N + CW;
  // The result delay line holds STAGES-1 entries.  With STAGES=1 it holds
  // one entry, which is fed straight from the input.
  localparam int RL = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic signed [PW-1:0] RND_K = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);

`ifdef MULC_SAT_EN
  localparam logic signed [PW-1:0] MAXV = PW'({1'b0, {(N-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV = ~MAXV;
`endif

  // Full-precision product, round-half-up, then an arithmetic shift
  // (a floor).  The rounding constant cannot overflow PW bits.
  function automatic logic signed [PW-1:0] round_shift(
    input logic signed [N-1:0]  d,
    input logic signed [CW-1:0] c
  );
    logic signed [PW-1:0] prod;
    prod = $signed({{CW{d[N-1]}}, d}) * $signed({{N{c[CW-1]}}, c});
    return (prod + RND_K) >>> FRAC;
  endfunction

  // Returns {sat_flag, N-bit result}.
  function automatic logic [N:0] saturate(input logic signed [PW-1:0] v);
`ifdef MULC_SAT_EN
    if (v > MAXV) return {1'b1, 1'b0, {(N-1){1'b1}}};
    if (v < MINV) return {1'b1, 1'b1, {(N-1){1'b0}}};
    return {1'b0, N'(v)};
`else
    return {1'b0, N'(v)};
`endif
  endfunction

  logic                 advance;
  logic signed [CW-1:0] coef;
  logic signed [N-1:0]  calc_d;
  logic signed [CW-1:0] calc_c;
  logic                 calc_v;
  logic [N:0]           calc_o;

  logic signed [N-1:0]  res_p [RL];
  logic                 sat_p [RL];
  logic                 vld_p [RL];

  // While RST is high the pipe counts as empty, so upstream sees ready.
  assign advance = EN && (RST || !R_OUT || RDY);
  assign A_OUT   = advance;

  // Coefficient writes do not depend on advance.  A sample accepted on the
  // same edge still captures the old value.
  always_ff @(posedge CLK) begin
    if (RST)
      coef <= COEF_INIT;
    else if (EN && C_WE)
      coef <= C_IN;
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign calc_d = D_IN;
      assign calc_c = coef;
      assign calc_v = R_IN;
    end else begin : g_p1
      logic signed [N-1:0]  d_p1;
      logic signed [CW-1:0] coef_p1;
      logic                 vld_p1;

      // ---- stage 1: capture the sample together with its coefficient ----
      always_ff @(posedge CLK) begin
        if (RST)
          vld_p1 <= 1'b0;
        else if (advance)
          vld_p1 <= R_IN;
      end

      always_ff @(posedge CLK) begin
        if (advance) begin
          d_p1    <= D_IN;
          coef_p1 <= coef;
        end
      end

      assign calc_d = d_p1;
      assign calc_c = coef_p1;
      assign calc_v = vld_p1;
    end
  endgenerate

  assign calc_o = saturate(round_shift(calc_d, calc_c));

  // ---- stage 2..STAGES: rounded result delay line, last entry is output ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RL; i++) vld_p[i] <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= calc_v;
      for (int i = 1; i < RL; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Only the output entry is cleared on reset.  The inner entries are
  // qualified by their valid bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_p[RL-1] <= '0;
      sat_p[RL-1] <= 1'b0;
    end else if (advance) begin
      res_p[0] <= calc_o[N-1:0];
      sat_p[0] <= calc_o[N];
      for (int i = 1; i < RL; i++) begin
        res_p[i] <= res_p[i-1];
        sat_p[i] <= sat_p[i-1];
      end
    end
  end

  assign R_OUT   = vld_p[RL-1];
  assign D_OUT   = res_p[RL-1];
  assign SAT_OUT = sat_p[RL-1];

endmodule

// File: tb/tb_mulc_pipe.sv
// -----------------------------------------------------------------------------
// tb_mulc_pipe -- self-checking bench for mulc_pipe (default parameters).
// Reference: the result of every sample is computed with 64-bit integer
// arithmetic, then pushed into a STAGES-deep delay line that moves only
// when the block can advance.  The checks compare the outputs with the
// delay line on every cycle.  Directed steps carry explicit constant checks.
// -----------------------------------------------------------------------------
module tb_mulc_pipe;
  localparam int N    = 16;
  localparam int CW   = 16;
  localparam int FRAC = 15;
  localparam int STG  = 2;

  logic          CLK = 1'b0;
  logic          RST, EN, R_IN, A_OUT, C_WE, RDY, R_OUT, SAT_OUT;
  logic [N-1:0]  D_IN, D_OUT;
  logic [CW-1:0] C_IN;

  always #5 CLK = ~CLK;

  mulc_pipe #(.N(N), .CW(CW), .FRAC(FRAC), .STAGES(STG), .COEF_INIT(16'h4000)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN), .A_OUT(A_OUT),
    .C_WE(C_WE), .C_IN(C_IN), .RDY(RDY), .R_OUT(R_OUT), .D_OUT(D_OUT),
    .SAT_OUT(SAT_OUT)
  );

  int          errors = 0;
  int          checks = 0;
  bit          m_v [STG];
  logic [15:0] m_d [STG];
  bit          m_s [STG];
  logic [15:0] mcoef;
  logic [15:0] got [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {sat, result}.
  function automatic logic [16:0] ref_mul(input logic [15:0] d, input logic [15:0] c);
    longint      p, r;
    logic [15:0] w;
    p = longint'($signed(d)) * longint'($signed(c));
    r = (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    w = r[15:0];
`ifdef MULC_SAT_EN
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, w};
  endfunction

  // Drives one cycle of inputs from the negedge.  Checks A_OUT before the
  // edge.  Updates the reference at the edge, then checks the outputs.
  task automatic cyc(input logic e, input logic rs, input logic v, input logic [15:0] d,
                     input logic w, input logic [15:0] c, input logic rd);
    logic [16:0] r;
    EN = e; RST = rs; R_IN = v; D_IN = d; C_WE = w; C_IN = c; RDY = rd;
    #1;
    chk("a_out", A_OUT, e && (rs || !m_v[STG-1] || rd));
    if (R_OUT && RDY && EN && !RST) got.push_back(D_OUT);
    @(posedge CLK);
    if (rs) begin
      for (int i = 0; i < STG; i++) m_v[i] = 1'b0;
      m_d[STG-1] = 16'h0;
      m_s[STG-1] = 1'b0;
      mcoef = 16'h4000;
    end else if (e) begin
      if (!m_v[STG-1] || rd) begin
        for (int i = STG - 1; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_s[i] = m_s[i-1];
        end
        r = ref_mul(d, mcoef);
        m_v[0] = v; m_d[0] = r[15:0]; m_s[0] = r[16];
      end
      if (w) mcoef = c;
    end
    #1;
    chk("r_out", R_OUT, m_v[STG-1]);
    if (m_v[STG-1]) begin
      chk("d_out", D_OUT, m_d[STG-1]);
      chk("sat_out", SAT_OUT, m_s[STG-1]);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < STG; i++) begin m_v[i] = 1'b0; m_d[i] = 16'h0; m_s[i] = 1'b0; end
    mcoef = 16'h4000;

    // Reset state
    cyc(1, 1, 0, 16'h0, 0, 16'h0, 1);
    cyc(1, 1, 0, 16'h0, 0, 16'h0, 1);
    chk("rst_r_out", R_OUT, 1'b0);
    chk("rst_d_out", D_OUT, 16'h0000);
    chk("rst_sat", SAT_OUT, 1'b0);

    // Basic latency: 0x1000 * 0.5 -> 0x0800 after two cycles
    cyc(1, 0, 1, 16'h1000, 0, 16'h0, 1);
    chk("lat_not_yet", R_OUT, 1'b0);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("lat_valid", R_OUT, 1'b1);
    chk("lat_data", D_OUT, 16'h0800);

    // Rounding: 3 -> 2, -3 -> -1
    cyc(1, 0, 1, 16'h0003, 0, 16'h0, 1);
    cyc(1, 0, 1, 16'hFFFD, 0, 16'h0, 1);
    chk("round_pos", D_OUT, 16'h0002);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("round_neg", D_OUT, 16'hFFFF);
    idle(2);

    // Full-scale corner: -1 * -1
    cyc(1, 0, 0, 16'h0, 1, 16'h8000, 1);
    cyc(1, 0, 1, 16'h8000, 0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
`ifdef MULC_SAT_EN
    chk("corner_data", D_OUT, 16'h7FFF);
    chk("corner_sat", SAT_OUT, 1'b1);
`else
    chk("corner_data", D_OUT, 16'h8000);
    chk("corner_sat", SAT_OUT, 1'b0);
`endif
    idle(2);

    // Backpressure stream 1..5 with RDY low for three cycles
    cyc(1, 0, 0, 16'h0, 1, 16'h7FFF, 1);
    idle(2);
    got.delete();
    cyc(1, 0, 1, 16'd1, 0, 16'h0, 1);
    cyc(1, 0, 1, 16'd2, 0, 16'h0, 1);
    cyc(1, 0, 1, 16'd3, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 16'd4, 0, 16'h0, 0);
      chk("stall_a_out", A_OUT, 1'b0);
      chk("stall_hold", D_OUT, 16'd2);
    end
    cyc(1, 0, 1, 16'd4, 0, 16'h0, 1);
    cyc(1, 0, 1, 16'd5, 0, 16'h0, 1);
    idle(4);
    chk("stream_len", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) chk("stream_val", got[i], 16'(i + 1));

    // Coefficient write in the same cycle as acceptance
    cyc(1, 0, 0, 16'h0, 1, 16'h4000, 1);
    cyc(1, 0, 1, 16'h1000, 1, 16'h2000, 1);
    cyc(1, 0, 1, 16'h1000, 0, 16'h0, 1);
    chk("cwe_old", D_OUT, 16'h0800);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("cwe_new", D_OUT, 16'h0400);
    idle(2);

    // EN=0 freezes everything, and a coefficient write is ignored
    cyc(1, 0, 1, 16'h4000, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h7777, 1, 16'h1234, 1);
    chk("en_frozen", R_OUT, 1'b0);
    cyc(1, 0, 1, 16'h1000, 0, 16'h0, 1);
    chk("en_resume", D_OUT, 16'h1000);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("en_coef_held", D_OUT, 16'h0400);
    idle(2);

    // Reset with two samples in flight
    cyc(1, 0, 1, 16'h1000, 0, 16'h0, 1);
    cyc(1, 0, 1, 16'h2000, 0, 16'h0, 1);
    cyc(1, 1, 1, 16'h3000, 0, 16'h0, 1);
    chk("midrst_r_out", R_OUT, 1'b0);
    idle(3);
    cyc(1, 0, 1, 16'h1000, 0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("midrst_coef", D_OUT, 16'h0800);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(9) != 0), 1'($urandom_range(60) == 0), 1'($urandom_range(1)),
          16'($urandom), 1'($urandom_range(7) == 0), 16'($urandom), 1'($urandom_range(3) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mulc_pipe.md
MULC_PIPE -- requirements
Module: mulc_pipe

Interface
- REQ-001 SHALL have parameter N, default 16: data width, signed two's complement.
- REQ-002 SHALL have parameter CW, default 16: coefficient width, signed.
- REQ-003 SHALL have parameter FRAC, default 15: coefficient fractional bits, legal range 1..CW-1.
- REQ-004 SHALL have parameter STAGES, default 2: pipeline latency in cycles, legal range 1..4.
- REQ-005 SHALL have parameter COEF_INIT, default 16'h4000: coefficient value after reset.
- REQ-006 SHALL have port CLK, input, 1: clock; all logic on the rising edge.
- REQ-007 SHALL have port RST, input, 1: reset, synchronous, active-high.
- REQ-008 SHALL have port EN, input, 1: global enable; low freezes the entire block.
- REQ-009 SHALL have port R_IN, input, 1: input sample valid.
- REQ-010 SHALL have port D_IN, input, N: input sample.
- REQ-011 SHALL have port A_OUT, output, 1: ready to upstream; sample accepted when R_IN && A_OUT.
- REQ-012 SHALL have port C_WE, input, 1: coefficient write strobe.
- REQ-013 SHALL have port C_IN, input, CW: new coefficient.
- REQ-014 SHALL have port RDY, input, 1: downstream ready.
- REQ-015 SHALL have port R_OUT, output, 1: output valid.
- REQ-016 SHALL have port D_OUT, output, N: output sample.
- REQ-017 SHALL have port SAT_OUT, output, 1: set when the current D_OUT was clamped.

Function
- REQ-018 SHALL compute D_OUT = clamp((D_IN*coef + 2^(FRAC-1)) >>> FRAC), with the full-precision product in N+CW bits and round-half-up.
- REQ-019 SHALL define advance = EN && (!R_OUT || RDY) and drive A_OUT = advance combinationally.
- REQ-020 SHALL shift every pipeline stage (data + valid bit) on advance only; a bubble (R_IN=0) enters as valid=0.
- REQ-021 SHALL present an accepted sample on R_OUT/D_OUT exactly STAGES advance cycles after acceptance; no data SHALL be lost or reordered under backpressure.
- REQ-022 SHALL hold R_OUT, D_OUT and SAT_OUT stable while R_OUT=1 and RDY=0.
- REQ-023 SHALL load C_IN into coef on a cycle with C_WE=1 and EN=1, independent of advance.
- REQ-024 SHALL process a sample accepted in the same cycle as C_WE using the old coefficient; samples accepted later SHALL use the new one.
- REQ-025 SHALL ignore all inputs, including C_WE, and hold all state when EN=0.
- REQ-026 SHALL latch the coefficient into the sample's stage-1 register at acceptance, so in-flight samples are unaffected by later writes.

Reset
- REQ-027 SHALL, with RST=1 at a clock edge, clear all stage valid bits, set R_OUT=0, D_OUT=0, SAT_OUT=0 and coef=COEF_INIT, regardless of EN.
- REQ-028 SHALL discard in-flight samples on reset mid-operation; the first accepted sample after reset appears after STAGES advance cycles.
- REQ-029 SHALL drive A_OUT=EN while RST=1, since the pipeline is empty.

Configuration
- REQ-030 SHALL, with macro MULC_SAT_EN defined, saturate the result to [-2^(N-1), 2^(N-1)-1] and set SAT_OUT=1 for that sample.
- REQ-031 SHALL, without MULC_SAT_EN, keep the low N bits (wrap-around) and tie SAT_OUT to 0.

Verification
- REQ-032 SHALL cover: N=16, FRAC=15, STAGES=2, coef=0x4000, D_IN=0x1000, RDY=1 -> R_OUT=1, D_OUT=0x0800 two cycles after acceptance.
- REQ-033 SHALL cover: coef=0x4000, D_IN=3 -> D_OUT=2 (rounding); D_IN=-3 (0xFFFD) -> D_OUT=0xFFFF.
- REQ-034 SHALL cover: coef=0x8000, D_IN=0x8000 -> D_OUT=0x7FFF with SAT_OUT=1 when MULC_SAT_EN is defined; D_OUT=0x8000 with SAT_OUT=0 otherwise.
- REQ-035 SHALL cover: stream 1,2,3,4,5 with coef=0x7FFF, RDY low for 3 cycles mid-stream -> A_OUT low while stalled, outputs 1,2,3,4,5 in order, no drops.
- REQ-036 SHALL cover: C_WE=1 with C_IN=0x2000 in the same cycle as accepting D_IN=0x1000, then D_IN=0x1000 again -> outputs 0x0800 then 0x0400.
- REQ-037 SHALL cover: RST pulsed with 2 samples in flight -> R_OUT=0 the next cycle, coef=0x4000, and neither sample emerges.
